// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern engine: movement modes, the
// two-state control FSM and the bounce direction flag.
package led_pkg;

    // Movement mode encodings, as presented on the mode input.
    localparam logic [1:0] MODE_ROL  = 2'b00;
    localparam logic [1:0] MODE_ROR  = 2'b01;
    localparam logic [1:0] MODE_BNC  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // Control FSM states. RUN is only left through reset.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Bounce direction: left moves lit LEDs towards the MSB.
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/led_pattern_engine_tick_gen.sv
// Prescaler for the LED pattern engine. Counts 0..TICK_DIV-1 while enabled
// and raises tick for the single cycle in which the count sits at its last
// value; the count wraps to 0 on the following edge. clr wins over en.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then wrap or increment while enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == CNT_LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Prescaler register, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && (count_q == CNT_LAST);

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine top. Loads a right-aligned seed of switch+1 lit LEDs on
// a button press (or on a switch change while running) and then moves it
// once per prescaled tick: rotate-left, rotate-right, bounce or hold.
// Build option: define LED_INPUT_SYNC_EN to pass button and switch through a
// 2-flop synchroniser (adds 2 cycles of latency to both).
// busy is the registered FSM state (1 = RUN) and doubles as its debug view.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int LED_W    = 16,
    parameter int SEL_W    = 3,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [SEL_W-1:0] switch,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             busy
);

    localparam int MSB = LED_W - 1;

    logic             btn_src;
    logic [SEL_W-1:0] sw_src;

`ifdef LED_INPUT_SYNC_EN
    logic [1:0]       btn_sync_q;
    logic [SEL_W-1:0] sw_sync1_q;
    logic [SEL_W-1:0] sw_sync2_q;

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_q <= '0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], button};
            sw_sync1_q <= switch;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    assign btn_src = btn_sync_q[1];
    assign sw_src  = sw_sync2_q;
`else
    assign btn_src = button;
    assign sw_src  = switch;
`endif

    logic             state_q, state_d;
    logic             dir_q, dir_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [SEL_W-1:0] sw_q, sw_d;
    logic             btn_q;

    logic             press;
    logic             sw_changed;
    logic             load;
    logic             tick;
    logic [LED_W-1:0] seed_v;

    assign press      = btn_src && !btn_q;
    assign sw_changed = (state_q == ST_RUN) && (sw_src != sw_q);
    // In IDLE only a press loads; a switch change counts only while running.
    assign load       = press || sw_changed;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (state_q == ST_RUN),
        .tick (tick)
    );

    // Seed: the low switch+1 bits lit, right-aligned.
    always_comb begin
        seed_v = '0;
        for (int i = 0; i < LED_W; i++) begin
            seed_v[i] = (i <= int'(sw_src));
        end
    end

    // Next-state: a load beats a tick; a tick applies one move in the current mode.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        led_d   = led_q;
        sw_d    = sw_q;
        if (load) begin
            state_d = ST_RUN;
            led_d   = seed_v;
            sw_d    = sw_src;
            dir_d   = (mode == MODE_ROR) ? DIR_R : DIR_L;
        end else if (tick) begin
            case (mode)
                MODE_ROL: led_d = {led_q[MSB-1:0], led_q[MSB]};
                MODE_ROR: led_d = {led_q[0], led_q[MSB:1]};
                MODE_BNC: begin
                    // A pattern filling the whole bank has nowhere to go.
                    if (led_q != '1) begin
                        if (dir_q == DIR_L) begin
                            if (led_q[MSB]) begin
                                dir_d = DIR_R;
                                led_d = led_q >> 1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                dir_d = DIR_L;
                                led_d = led_q << 1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                end
                default: led_d = led_q;
            endcase
        end
    end

    // State registers; reset returns to IDLE with all LEDs lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_L;
            led_q   <= '1;
            sw_q    <= '0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            sw_q    <= sw_d;
            btn_q   <= btn_src;
        end
    end

    assign led  = led_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with LED_W=16, SEL_W=3, TICK_DIV=4.
// A table of {switch, mode, ticks, expected led} records drives most checks;
// hand-written sequences cover reset mid-run, a held button, a switch change
// on the tick cycle, hold-mode reload and entering bounce with dir = right.
module tb_led_pattern_engine;

    localparam int LED_W    = 16;
    localparam int SEL_W    = 3;
    localparam int TICK_DIV = 4;

    logic             clk;
    logic             rst;
    logic             button;
    logic [SEL_W-1:0] switch;
    logic [1:0]       mode;
    logic [LED_W-1:0] led;
    logic             busy;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [SEL_W-1:0] sw;
        logic [1:0]       md;
        int               ticks;
        logic [LED_W-1:0] exp_led;
    } vec_t;

    vec_t vecs[13];

    led_pattern_engine #(
        .LED_W    (LED_W),
        .SEL_W    (SEL_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .switch (switch),
        .mode   (mode),
        .led    (led),
        .busy   (busy)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LED_W-1:0] act,
                         input logic [LED_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One-cycle press; returns at the negedge just after the loading edge.
    task automatic press(input logic [SEL_W-1:0] sw, input logic [1:0] md);
        @(negedge clk);
        switch = sw;
        mode   = md;
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TICK_DIV) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        button   = 1'b0;
        switch   = '0;
        mode     = 2'b00;

        vecs[0]  = '{3'd2, 2'b00, 1,  16'h000E};
        vecs[1]  = '{3'd2, 2'b01, 1,  16'h8003};
        vecs[2]  = '{3'd2, 2'b01, 3,  16'hE000};
        vecs[3]  = '{3'd0, 2'b00, 15, 16'h8000};
        vecs[4]  = '{3'd0, 2'b00, 16, 16'h0001};
        vecs[5]  = '{3'd1, 2'b10, 14, 16'hC000};
        vecs[6]  = '{3'd1, 2'b10, 15, 16'h6000};
        vecs[7]  = '{3'd1, 2'b10, 28, 16'h0003};
        vecs[8]  = '{3'd1, 2'b10, 29, 16'h0006};
        vecs[9]  = '{3'd7, 2'b10, 8,  16'hFF00};
        vecs[10] = '{3'd7, 2'b10, 9,  16'h7F80};
        vecs[11] = '{3'd3, 2'b11, 5,  16'h000F};
        vecs[12] = '{3'd4, 2'b00, 0,  16'h001F};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_led", led, 16'hFFFF);
        check_bit("reset_busy", busy, 1'b0);
        rst = 1'b0;

        // IDLE ignores ticks and switch changes.
        switch = 3'd5;
        repeat (10) @(negedge clk);
        check("idle_led", led, 16'hFFFF);
        check_bit("idle_busy", busy, 1'b0);

        // First press: seed and busy, then one move after TICK_DIV cycles.
        @(negedge clk);
        switch = 3'd2;
        mode   = 2'b00;
        button = 1'b1;
        @(negedge clk);
        check("press_seed", led, 16'h0007);
        check_bit("press_busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        check("pre_first_move", led, 16'h0007);
        @(negedge clk);
        check("first_move", led, 16'h000E);
        // Button still held: no reload, pattern keeps moving (5 ticks total).
        repeat (16) @(negedge clk);
        check("held_button", led, 16'h00E0);
        button = 1'b0;

        // Table-driven vectors: fresh press, run N ticks, compare.
        for (int i = 0; i < 13; i++) begin
            press(vecs[i].sw, vecs[i].md);
            wait_ticks(vecs[i].ticks);
            check($sformatf("vec%0d", i), led, vecs[i].exp_led);
        end

        // Rotate-left wrap, then mode change to rotate-right without reload.
        press(3'd0, 2'b00);
        wait_ticks(31);
        check("rol_tick31", led, 16'h8000);
        mode = 2'b01;
        wait_ticks(1);
        check("mode_to_ror", led, 16'h4000);

        // Entering bounce keeps dir = right set by the rotate-right load.
        press(3'd0, 2'b01);
        wait_ticks(2);
        check("ror_two", led, 16'h4000);
        mode = 2'b10;
        wait_ticks(1);
        check("bnc_keeps_dir", led, 16'h2000);

        // Switch change on the tick cycle: load wins, prescaler restarts.
        press(3'd2, 2'b00);
        repeat (3) @(negedge clk);
        switch = 3'd4;
        @(negedge clk);
        check("sw_change_load", led, 16'h001F);
        repeat (3) @(negedge clk);
        check("sw_change_no_move", led, 16'h001F);
        @(negedge clk);
        check("sw_change_move", led, 16'h003E);

        // Press in hold mode reloads the seed, which then stays put.
        press(3'd4, 2'b11);
        check("hold_reload", led, 16'h001F);
        wait_ticks(3);
        check("hold_static", led, 16'h001F);

        // Asynchronous reset mid-run from 0x0030.
        press(3'd1, 2'b00);
        wait_ticks(4);
        check("pre_reset", led, 16'h0030);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", led, 16'hFFFF);
        check_bit("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(3);
        check("post_rst_led", led, 16'hFFFF);
        check_bit("post_rst_busy", busy, 1'b0);
        press(3'd0, 2'b00);
        check("post_rst_press", led, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
